// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and
// default sizing.
package prog_loader_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, program RAM write port out. The loader is the slave of
// the stream and drives the RAM write signals.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/prog_loader_timeout.sv
// Saturating idle-cycle counter. hit flags the cycle in which the count
// would reach TIMEOUT, so the owner can abort on that same edge.
module loader_timeout #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Count idle cycles; clear wins, saturate at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT))) begin
            count <= count + CW'(1);
        end
    end

    assign hit = enable && !clear && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/prog_loader.sv
// Program-memory loader: assembles big-endian 16-bit words from a byte
// stream, writes them to program RAM, verifies an XOR checksum and then
// releases the fetch unit via core_en.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    prog_loader_if.slave    bus,
    output logic            core_en,
    output logic            done,
    output logic            err,
    output logic [ADDR_W:0] word_count
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    state_t            state_nx;
    logic              ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [7:0]        hi_q;
    logic [7:0]        csum_q;
    logic [ADDR_W:0]   len_q;
    logic              xfer;
    logic              in_frame;
    logic              last_word;
    logic              hit;

    assign xfer      = bus.byte_valid && ready_q;
    assign in_frame  = (state == ST_HI) || (state == ST_LO) || (state == ST_CSUM);
    assign last_word = ((word_count + 1'b1) == len_q);

    assign bus.byte_ready = ready_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;

    loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (xfer || !in_frame),
        .enable (in_frame),
        .hit    (hit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; a transfer always takes priority over a timeout.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_nx = ST_LEN;
            ST_LEN:  if (xfer) state_nx = ST_HI;
            ST_HI: begin
                if (xfer)     state_nx = ST_LO;
                else if (hit) state_nx = ST_ERR;
            end
            ST_LO: begin
                if (xfer)     state_nx = last_word ? ST_CSUM : ST_HI;
                else if (hit) state_nx = ST_ERR;
            end
            ST_CSUM: begin
                if (xfer)     state_nx = (bus.byte_in == csum_q) ? ST_DONE : ST_ERR;
                else if (hit) state_nx = ST_ERR;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Status outputs and byte_ready are registered from the next state, so
    // they change on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            core_en <= 1'b0;
        end else begin
            ready_q <= (state_nx == ST_LEN) || (state_nx == ST_HI) ||
                       (state_nx == ST_LO)  || (state_nx == ST_CSUM);
            done    <= (state_nx == ST_DONE);
            err     <= (state_nx == ST_ERR);
            core_en <= (state_nx == ST_DONE);
        end
    end

    // Frame datapath: length latch, word assembly, RAM write, checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hi_q       <= '0;
            csum_q     <= '0;
            len_q      <= '0;
            word_count <= '0;
        end else begin
            we_q <= 1'b0;
            if (xfer) begin
                unique case (state)
                    ST_LEN: begin
                        len_q      <= (bus.byte_in == 8'h00) ? DEPTH : (ADDR_W + 1)'(bus.byte_in);
                        csum_q     <= '0;
                        word_count <= '0;
                        addr_q     <= '0;
                    end
                    ST_HI: begin
                        hi_q   <= bus.byte_in;
                        csum_q <= csum_q ^ bus.byte_in;
                    end
                    ST_LO: begin
                        csum_q     <= csum_q ^ bus.byte_in;
                        we_q       <= 1'b1;
                        wdata_q    <= {hi_q, bus.byte_in};
                        addr_q     <= word_count[ADDR_W-1:0];
                        word_count <= word_count + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a write scoreboard derived from the
// frames being sent, checked on every clock, plus end-of-frame results.
module tb_prog_loader;

    localparam int unsigned AW = 8;
    localparam int unsigned TO = 1024;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          core_en;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    prog_loader_if #(.ADDR_W(AW)) bus ();

    prog_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .core_en    (core_en),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    int          writes_seen = 0;
    logic        prev_we = 1'b0;
    bit          loading = 1'b0;
    logic [15:0] first_data = '0;
    logic [15:0] last_data = '0;
    logic [AW-1:0] last_addr = '0;
    bit          first_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xor_of(input byte_q_t p);
        logic [7:0] x = '0;
        foreach (p[i]) x ^= p[i];
        return x;
    endfunction

    // Per-cycle scoreboard: every write must be the next expected word.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we = 1'b0;
        end else begin
            if (bus.mem_we) begin
                writes_seen++;
                check("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("mem_addr", 32'(bus.mem_addr), 32'(w.addr));
                    check("mem_wdata", 32'(bus.mem_wdata), 32'(w.data));
                    check("word_count_at_write", 32'(word_count), 32'(w.addr) + 1);
                end
                if (first_pending) begin
                    first_data    = bus.mem_wdata;
                    first_pending = 1'b0;
                end
                last_data = bus.mem_wdata;
                last_addr = bus.mem_addr;
            end
            check("we_not_back_to_back", 32'(bus.mem_we & prev_we), 0);
            if (loading) check("core_en_low_in_load", 32'(core_en), 0);
            prev_we = bus.mem_we;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned n = 0;
        repeat (gap) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
        end
        @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.byte_ready) begin
            check("byte_ready_wait", 0, 1);
            bus.byte_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle_bus();
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends LEN, payload, checksum; the expected write for each word is
    // queued just before its low byte goes out. inject_start pulses start
    // after LEN, which the loader must ignore.
    task automatic send_frame(input logic [7:0] len, input byte_q_t p, input logic [7:0] cs,
                              input int unsigned maxgap, input bit inject_start);
        wr_t w;
        first_pending = 1'b1;
        send_byte(len, 0);
        if (inject_start) pulse_start();
        for (int i = 0; i < p.size(); i++) begin
            if (i % 2 == 1) begin
                w.addr = AW'(i / 2);
                w.data = {p[i-1], p[i]};
                exp_q.push_back(w);
            end
            send_byte(p[i], $urandom_range(0, maxgap));
        end
        send_byte(cs, $urandom_range(0, maxgap));
        loading = 1'b0;
        idle_bus();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, 32'(bus.byte_ready), 0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
        check({tag, "_core_en"}, 32'(core_en), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_word_count"}, 32'(word_count), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte_q_t f1;
        byte_q_t big;
        byte_q_t f6;
        int      base;
        wr_t     w;

        f1 = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        // 1: good frame; 12^34^AB^CD^00^FF = BF by hand
        base = writes_seen;
        pulse_start();
        loading = 1'b1;
        check("len_ready", 32'(bus.byte_ready), 1);
        send_frame(8'h03, f1, 8'hBF, 0, 1'b0);
        check("t1_done", 32'(done), 1);
        check("t1_core_en", 32'(core_en), 1);
        check("t1_err", 32'(err), 0);
        check("t1_word_count", 32'(word_count), 3);
        check("t1_writes", 32'(writes_seen - base), 3);
        check("t1_first_word", 32'(first_data), 32'h1234);
        check("t1_last_word", 32'(last_data), 32'h00FF);
        check("t1_last_addr", 32'(last_addr), 2);
        check("t1_ready_low", 32'(bus.byte_ready), 0);
        check("t1_queue_empty", 32'(exp_q.size()), 0);

        // 2: same frame, wrong checksum
        base = writes_seen;
        pulse_start();
        loading = 1'b1;
        send_frame(8'h03, f1, 8'h8B, 0, 1'b0);
        check("t2_err", 32'(err), 1);
        check("t2_done", 32'(done), 0);
        check("t2_core_en", 32'(core_en), 0);
        check("t2_word_count", 32'(word_count), 3);
        check("t2_writes", 32'(writes_seen - base), 3);

        // 3: random valid gaps and an ignored mid-load start
        base = writes_seen;
        pulse_start();
        loading = 1'b1;
        send_frame(8'h03, f1, xor_of(f1), 6, 1'b1);
        check("t3_done", 32'(done), 1);
        check("t3_core_en", 32'(core_en), 1);
        check("t3_word_count", 32'(word_count), 3);
        check("t3_writes", 32'(writes_seen - base), 3);
        check("t3_last_word", 32'(last_data), 32'h00FF);

        // 4: stall after second payload byte
        pulse_start();
        loading = 1'b1;
        send_byte(8'h03, 0);
        w.addr = '0;
        w.data = 16'h1234;
        exp_q.push_back(w);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        idle_bus();
        repeat (998) @(negedge clk);
        check("t4_no_err_early", 32'(err), 0);
        check("t4_still_ready", 32'(bus.byte_ready), 1);
        repeat (100) @(negedge clk);
        loading = 1'b0;
        check("t4_err", 32'(err), 1);
        check("t4_done", 32'(done), 0);
        check("t4_core_en", 32'(core_en), 0);
        check("t4_word_count", 32'(word_count), 1);
        check("t4_ready_low", 32'(bus.byte_ready), 0);

        // 5: LEN=0 -> 256 words; hi=i, lo=i^5A; both XOR to 00 over a full byte range
        for (int i = 0; i < 256; i++) begin
            big.push_back(8'(i));
            big.push_back(8'(i) ^ 8'h5A);
        end
        base = writes_seen;
        pulse_start();
        loading = 1'b1;
        send_frame(8'h00, big, 8'h00, 0, 1'b0);
        check("t5_done", 32'(done), 1);
        check("t5_err", 32'(err), 0);
        check("t5_word_count", 32'(word_count), 256);
        check("t5_writes", 32'(writes_seen - base), 256);
        check("t5_last_addr", 32'(last_addr), 32'hFF);
        check("t5_last_word", 32'(last_data), 32'hFFA5);

        // 6: async reset mid-load, then restart from DONE
        pulse_start();
        loading = 1'b1;
        send_byte(8'h02, 0);
        w.addr = '0;
        w.data = 16'h1122;
        exp_q.push_back(w);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        idle_bus();
        #2;
        rst_n = 1'b0;
        loading = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        pulse_start();
        loading = 1'b1;
        send_frame(8'h03, f1, 8'hBF, 0, 1'b0);
        check("t6_done", 32'(done), 1);
        check("t6_core_en", 32'(core_en), 1);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("t6_core_en_drop", 32'(core_en), 0);
        check("t6_done_drop", 32'(done), 0);
        check("t6_len_ready", 32'(bus.byte_ready), 1);
        @(negedge clk);
        start = 1'b0;
        loading = 1'b1;
        // 5A^A5^3C^C3 = 00
        f6 = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
        base = writes_seen;
        send_frame(8'h02, f6, 8'h00, 0, 1'b0);
        check("t6b_done", 32'(done), 1);
        check("t6b_word_count", 32'(word_count), 2);
        check("t6b_writes", 32'(writes_seen - base), 2);
        check("t6b_last_word", 32'(last_data), 32'h3CC3);
        check("t6b_queue_empty", 32'(exp_q.size()), 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
